// File: rtl/cam_pkg.sv
// Shared constants and types for the CAM access controller.
package cam_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = AW + 1;

  localparam logic SRC_LOOKUP = 1'b0;
  localparam logic SRC_INSERT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_WAIT,
    ST_EVAL,
    ST_WRITE,
    ST_RESP,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/cam_rr_arb.sv
// Two-input round-robin arbiter; the pointer only advances on a contested grant.
module cam_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic ptr;

  always_comb begin
    gnt_c = 2'b00;
    if (en) begin
      if (&req) gnt_c = ptr ? 2'b10 : 2'b01;
      else      gnt_c = req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ptr <= 1'b0;
    else if (en && (&req)) ptr <= ~ptr;
  end

endmodule

// File: rtl/cam_access_ctrl.sv
// Sequencer/arbiter sharing one CAM between lookup and insert requesters,
// with search-before-write dedup, occupancy tracking and flush.
module cam_access_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned SRCH_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lk_req,
  input  logic [DW-1:0] lk_key,
  output logic          lk_gnt,
  input  logic          ins_req,
  input  logic [DW-1:0] ins_key,
  output logic          ins_gnt,
  input  logic          flush_req,
  output logic          flush_done,
  output logic          rsp_valid,
  output logic          rsp_src,
  output logic          rsp_hit,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_full,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          cam_reset,
  output logic          cam_en,
  output logic          cam_we,
  output logic [DW-1:0] cam_din,
  input  logic          cam_match,
  input  logic [AW-1:0] cam_match_addr
);

  state_e     state;
  logic       src_q;
  logic [1:0] wait_cnt;
  logic [1:0] arb_gnt;
  logic       arb_en;

  // Grants are only issued from IDLE and never while a flush is pending.
  assign arb_en  = (state == ST_IDLE) && !flush_req;
  assign lk_gnt  = arb_gnt[0];
  assign ins_gnt = arb_gnt[1];
  assign full    = (count == CW'(DEPTH));

  cam_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({ins_req, lk_req}),
    .gnt_c (arb_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      src_q      <= SRC_LOOKUP;
      wait_cnt   <= 2'd0;
      count      <= '0;
      cam_reset  <= 1'b1;
      cam_en     <= 1'b0;
      cam_we     <= 1'b0;
      cam_din    <= '0;
      flush_done <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_src    <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_addr   <= '0;
      rsp_full   <= 1'b0;
    end else begin
      cam_reset  <= 1'b0;
      flush_done <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_full   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            cam_reset <= 1'b1;
            count     <= '0;
            state     <= ST_FLUSH;
          end else if (|arb_gnt) begin
            src_q    <= arb_gnt[1];
            cam_din  <= arb_gnt[1] ? ins_key : lk_key;
            cam_en   <= 1'b1;
            cam_we   <= 1'b0;
            wait_cnt <= 2'd0;
            state    <= ST_SEARCH;
          end
        end
        ST_SEARCH, ST_WAIT: begin
          if (wait_cnt == 2'(SRCH_LAT - 1)) begin
            cam_en <= 1'b0;
            state  <= ST_EVAL;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
            state    <= ST_WAIT;
          end
        end
        ST_EVAL: begin
          // Only a non-duplicate insert with room left turns into a write.
          if (src_q == SRC_INSERT && !cam_match && count != CW'(DEPTH)) begin
            cam_en <= 1'b1;
            cam_we <= 1'b1;
            state  <= ST_WRITE;
          end else begin
            rsp_valid <= 1'b1;
            rsp_src   <= src_q;
            rsp_hit   <= cam_match;
            rsp_addr  <= cam_match ? cam_match_addr : '0;
            rsp_full  <= (src_q == SRC_INSERT) && !cam_match;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          cam_en    <= 1'b0;
          cam_we    <= 1'b0;
          count     <= count + CW'(1);
          rsp_valid <= 1'b1;
          rsp_src   <= SRC_INSERT;
          rsp_hit   <= 1'b0;
          rsp_addr  <= count[AW-1:0];
          state     <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        ST_FLUSH: begin
          // First FLUSH cycle holds cam_reset, second one signals completion.
          if (cam_reset) flush_done <= 1'b1;
          else           state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Scoreboard bench for cam_access_ctrl with a behavioural 16x16 CAM attached.
module tb_cam_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        lk_req, ins_req, flush_req;
  logic [15:0] lk_key, ins_key;
  logic        lk_gnt, ins_gnt, flush_done;
  logic        rsp_valid, rsp_src, rsp_hit, rsp_full;
  logic [3:0]  rsp_addr;
  logic [4:0]  count;
  logic        full, cam_reset, cam_en, cam_we;
  logic [15:0] cam_din;
  logic        cam_match;
  logic [3:0]  cam_match_addr;

  always #5 clk = ~clk;

  cam_access_ctrl #(.SRCH_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .lk_req(lk_req), .lk_key(lk_key), .lk_gnt(lk_gnt),
    .ins_req(ins_req), .ins_key(ins_key), .ins_gnt(ins_gnt),
    .flush_req(flush_req), .flush_done(flush_done),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_full(rsp_full),
    .count(count), .full(full),
    .cam_reset(cam_reset), .cam_en(cam_en), .cam_we(cam_we), .cam_din(cam_din),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  // Behavioural CAM: sequential write slot, one-cycle search latency, lowest index wins.
  logic [15:0] cmem [16];
  logic [15:0] cvalid;
  logic [3:0]  cwp;

  always @(posedge clk) begin
    if (cam_reset) begin
      cvalid <= '0;
      cwp    <= '0;
    end else if (cam_en && cam_we) begin
      cmem[cwp]   <= cam_din;
      cvalid[cwp] <= 1'b1;
      cwp         <= cwp + 4'd1;
    end
    cam_match      <= 1'b0;
    cam_match_addr <= '0;
    if (cam_en && !cam_we) begin
      for (int i = 15; i >= 0; i--) begin
        if (cvalid[i] && cmem[i] == cam_din) begin
          cam_match      <= 1'b1;
          cam_match_addr <= 4'(i);
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       src;
    logic       hit;
    logic [3:0] addr;
    logic       full;
    int         cyc;
    logic [4:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic        gnt_log[$];
  int          gnt_cyc[$];
  logic [15:0] ref_keys [16];
  int          ref_cnt = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          cr_cnt = 0;
  int          cr_cyc = 0;
  int          rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: builds the expected response at each grant, checks it at RESP.
  exp_t        e, got;
  logic [15:0] m_key;
  logic        m_hit;
  int          m_addr;

  always @(negedge clk) begin
    if (!reset) begin
      if (cam_we) we_cnt++;
      if (cam_reset) begin
        cr_cnt++;
        cr_cyc  = cyc;
        ref_cnt = 0;
      end
      if (lk_gnt || ins_gnt) begin
        m_key  = ins_gnt ? ins_key : lk_key;
        m_hit  = 1'b0;
        m_addr = 0;
        for (int i = 0; i < ref_cnt; i++) begin
          if (!m_hit && ref_keys[i] == m_key) begin
            m_hit  = 1'b1;
            m_addr = i;
          end
        end
        e.src  = ins_gnt;
        e.hit  = m_hit;
        e.addr = 4'(m_addr);
        e.full = 1'b0;
        e.cyc  = cyc + 3;
        if (ins_gnt && !m_hit) begin
          if (ref_cnt < 16) begin
            e.addr            = 4'(ref_cnt);
            ref_keys[ref_cnt] = m_key;
            ref_cnt++;
            e.cyc = cyc + 4;
          end else begin
            e.full = 1'b1;
          end
        end
        e.cnt = 5'(ref_cnt);
        sb.push_back(e);
        gnt_log.push_back(ins_gnt);
        gnt_cyc.push_back(cyc);
      end
      if (rsp_valid) begin
        rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          got = sb.pop_front();
          check_eq("rsp_src", 32'(rsp_src), 32'(got.src));
          check_eq("rsp_hit", 32'(rsp_hit), 32'(got.hit));
          check_eq("rsp_full", 32'(rsp_full), 32'(got.full));
          if (!got.full) check_eq("rsp_addr", 32'(rsp_addr), 32'(got.addr));
          check_eq("rsp_lat", 32'(cyc), 32'(got.cyc));
          check_eq("rsp_count", 32'(count), 32'(got.cnt));
        end
      end
    end
  end

  task automatic do_req(input logic src, input logic [15:0] key);
    int   n;
    logic g;
    @(posedge clk); #1;
    if (src) begin ins_req = 1'b1; ins_key = key; end
    else     begin lk_req  = 1'b1; lk_key  = key; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = src ? ins_gnt : lk_gnt;
    end while (!g && n < 100);
    if (!g) check_eq("gnt_timeout", 32'(g), 32'd1);
    @(posedge clk); #1;
    lk_req  = 1'b0;
    ins_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic txn(input logic src, input logic [15:0] key);
    do_req(src, key);
    drain();
  endtask

  int we0, cr0, gb, n;

  initial begin
    reset = 1'b1; lk_req = 1'b0; ins_req = 1'b0; flush_req = 1'b0;
    lk_key = '0; ins_key = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_cam_reset", 32'(cam_reset), 32'd1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_cam_en", 32'(cam_en), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    txn(1'b1, 16'h0001);
    txn(1'b1, 16'h0002);
    txn(1'b1, 16'h0004);
    check_eq("count_3", 32'(count), 32'd3);

    txn(1'b0, 16'h0002);
    txn(1'b0, 16'h0099);
    check_eq("lookup_count", 32'(count), 32'd3);

    txn(1'b1, 16'h0005);
    txn(1'b1, 16'h0006);
    txn(1'b1, 16'h0007);
    we0 = we_cnt;
    txn(1'b1, 16'h0007);
    check_eq("dup_no_we", 32'(we_cnt - we0), 32'd0);
    check_eq("dup_count", 32'(count), 32'd6);

    for (int i = 0; i < 10; i++) txn(1'b1, 16'h0010 + 16'(i));
    check_eq("fill_count", 32'(count), 32'd16);
    check_eq("fill_full", 32'(full), 32'd1);
    we0 = we_cnt;
    txn(1'b1, 16'h0030);
    check_eq("full_no_we", 32'(we_cnt - we0), 32'd0);
    check_eq("full_count", 32'(count), 32'd16);

    // Flush raised while a lookup is in SEARCH.
    cr0 = cr_cnt;
    @(posedge clk); #1;
    lk_req = 1'b1; lk_key = 16'h0001;
    n = 0;
    do begin @(negedge clk); n++; end while (!lk_gnt && n < 100);
    check_eq("flush_lk_gnt", 32'(lk_gnt), 32'd1);
    @(posedge clk); #1;
    lk_req = 1'b0; flush_req = 1'b1;
    check_eq("flush_search_en", 32'(cam_en), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!flush_done && n < 50);
    check_eq("flush_done_seen", 32'(flush_done), 32'd1);
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_cr_pulses", 32'(cr_cnt - cr0), 32'd1);
    check_eq("flush_after_rsp", 32'(cr_cyc > rsp_cyc), 32'd1);
    check_eq("flush_done_lat", 32'(cyc - cr_cyc), 32'd1);
    @(posedge clk); #1;
    flush_req = 1'b0;
    drain();
    txn(1'b0, 16'h0001);

    // Both requesters held: grants must alternate, one per transaction.
    gb = gnt_log.size();
    @(posedge clk); #1;
    lk_req = 1'b1; lk_key = 16'h00A0;
    ins_req = 1'b1; ins_key = 16'h00B0;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt_log.size() < gb + 4 && n < 200);
    @(posedge clk); #1;
    lk_req = 1'b0; ins_req = 1'b0;
    drain();
    check_eq("alt_grants", 32'(gnt_log.size() - gb), 32'd4);
    if (gnt_log.size() >= gb + 4) begin
      for (int i = 0; i < 4; i++) check_eq("alt_src", 32'(gnt_log[gb+i]), 32'(i % 2));
      check_eq("alt_gap0", 32'(gnt_cyc[gb+1] - gnt_cyc[gb]), 32'd4);
      check_eq("alt_gap1", 32'(gnt_cyc[gb+2] - gnt_cyc[gb+1]), 32'd5);
      check_eq("alt_gap2", 32'(gnt_cyc[gb+3] - gnt_cyc[gb+2]), 32'd4);
    end
    check_eq("alt_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cam_access_ctrl.md
Name: cam_access_ctrl

Overview:
- Sequencer and arbiter in front of the 16x16 CAM. The CAM has ports EN, WE, DIN, match and match_addr, and writes each entry to the next sequential slot.
- Shares the CAM between a lookup requester and an insert requester.
- Turns each insert into search-then-write, so no duplicate entries are stored.
- Tracks CAM occupancy, reports full, and sequences a flush through the CAM reset.

Parameters:
- DW, 16, key width; equals the CAM DIN width.
- DEPTH, 16, number of CAM entries.
- AW, 4, address width, log2(DEPTH).
- SRCH_LAT, 1, cycles from search presentation (EN=1, WE=0) to a valid match/match_addr; range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- lk_req  in  1  lookup request; held high until lk_gnt.
- lk_key  in  DW  lookup key; sampled in the lk_gnt cycle.
- lk_gnt  out  1  one-cycle lookup grant.
- ins_req  in  1  insert request; held high until ins_gnt.
- ins_key  in  DW  insert key; sampled in the ins_gnt cycle.
- ins_gnt  out  1  one-cycle insert grant.
- flush_req  in  1  request to clear the CAM; level-sensitive.
- flush_done  out  1  one-cycle pulse when the flush completes.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_src  out  1  0 = lookup, 1 = insert.
- rsp_hit  out  1  key already present.
- rsp_addr  out  AW  entry address (hit address or newly written slot).
- rsp_full  out  1  insert rejected because the CAM is full (miss with count==DEPTH).
- count  out  AW+1  occupied entries, 0..DEPTH.
- full  out  1  count==DEPTH.
- cam_reset  out  1  drives CAM reset.
- cam_en  out  1  drives CAM EN.
- cam_we  out  1  drives CAM WE.
- cam_din  out  DW  drives CAM DIN.
- cam_match  in  1  from CAM match.
- cam_match_addr  in  AW  from CAM match_addr.

Behaviour:
- Reset:
  - State IDLE.
  - All grant, strobe and response outputs 0.
  - count=0, full=0.
  - cam_reset=1 while reset is asserted; cam_en=0, cam_we=0, cam_din=0.
  - Round-robin pointer favours lookup.
- States: IDLE, SEARCH, WAIT, EVAL, WRITE, RESP, FLUSH.
- IDLE priority:
  - flush_req outranks all requests.
  - Between lookup and insert, round-robin. The pointer toggles to the other source after each grant, and only when both requests are pending.
  - A single pending request is granted immediately.
  - At most one grant per transaction. The key is captured into a register at grant.
- IDLE -> FLUSH on flush_req:
  - cam_reset=1 for exactly 1 cycle; count cleared.
  - flush_done pulses in the next cycle, then IDLE.
  - A flush_req raised mid-transaction is held off until IDLE; an in-flight transaction always completes.
- Grant at cycle T -> SEARCH at T+1:
  - cam_en=1, cam_we=0, cam_din=captured key.
  - cam_en/cam_din stay driven through WAIT.
  - SRCH_LAT-1 WAIT cycles follow.
- EVAL at T+1+SRCH_LAT samples cam_match/cam_match_addr into registers.
- Lookup:
  - RESP at T+2+SRCH_LAT: rsp_valid=1, rsp_src=0, rsp_hit=match, rsp_addr=match_addr (0 on miss).
  - count is unchanged.
- Insert hit: RESP at T+2+SRCH_LAT with rsp_hit=1 and rsp_addr=match_addr; no write.
- Insert miss, count<DEPTH:
  - WRITE at T+2+SRCH_LAT: cam_en=1, cam_we=1, cam_din=key.
  - count increments at the end of WRITE.
  - RESP at T+3+SRCH_LAT: rsp_hit=0, rsp_addr=old count[AW-1:0].
- Insert miss, count==DEPTH: RESP with rsp_full=1 and rsp_hit=0; no write; count stays at DEPTH, with no wrap.
- RESP -> IDLE. A new grant is possible in the cycle after RESP, so throughput is 1 transaction per SRCH_LAT+3 (or +4) cycles.
- rsp_* fields are valid only when rsp_valid=1. Otherwise they hold their last values, except rsp_full, which is 0 outside RESP.
- full is combinational from count.
- Reset asserted mid-operation: immediate return to IDLE, no response issued; requesters must re-request.
- cam_en=0 outside SEARCH, WAIT and WRITE.

Decomposition:
- Package cam_pkg holds:
  - the DW, DEPTH and AW constants;
  - the state enum;
  - the SRC_LOOKUP/SRC_INSERT constants.
- One sub-module, cam_rr_arb: a 2-input round-robin arbiter with a grant-enable input and a registered priority pointer.
- The FSM, key register and occupancy counter stay in cam_access_ctrl.

Test Plan:
- Reset, then insert 16'h0001, 16'h0002, 16'h0004 -> each rsp_hit=0; rsp_addr=0,1,2; count=3; insert rsp at grant+4 with SRCH_LAT=1.
- Lookup 16'h0002 -> rsp_hit=1, rsp_addr=1, rsp_src=0, rsp_valid at grant+3. Lookup 16'h0099 -> rsp_hit=0, count unchanged.
- Insert duplicate 16'h0007 after it already sits at addr 5 -> rsp_hit=1, rsp_addr=5, no cam_we pulse, count unchanged.
- Fill 16 unique keys, then insert 16'h0030 -> rsp_full=1, full=1, count=16, no cam_we.
- lk_req and ins_req held continuously -> grants alternate L, I, L, I; each request granted once per transaction.
- flush_req raised during a SEARCH -> the transaction completes, then cam_reset pulses for 1 cycle, flush_done follows, count=0, and lookup of 16'h0001 misses.
